// File: rtl/usb_pulpino_channel_ctrl_if.sv
// Signal bundle between the USB register side / channel and usb_pulpino_channel_ctrl.
// slave = the sequencer itself, master = whatever drives it (register block / bench).
interface usb_pulpino_channel_ctrl_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      tx_data_i;
  logic             tx_valid_i;
  logic             tx_ready_o;
  logic [LVL_W-1:0] tx_level_o;
  logic             tx_done_o;
  logic [31:0]      chan_word_o;
  logic             chan_load_o;
  logic             chan_usb_write_flicker_i;
  logic             chan_pulpino_read_flicker_i;
  logic             chan_usb_read_flicker_i;
  logic [31:0]      chan_rx_word_i;
  logic [31:0]      rx_data_o;
  logic             rx_valid_o;
  logic             rx_ready_i;
  logic             abort_i;
  logic             clr_status_i;
  logic             busy_o;
  logic             timeout_o;
  logic             rx_overflow_o;

  modport slave (
    input  tx_data_i, tx_valid_i, chan_usb_write_flicker_i, chan_pulpino_read_flicker_i,
           chan_usb_read_flicker_i, chan_rx_word_i, rx_ready_i, abort_i, clr_status_i,
    output tx_ready_o, tx_level_o, tx_done_o, chan_word_o, chan_load_o, rx_data_o,
           rx_valid_o, busy_o, timeout_o, rx_overflow_o
  );

  modport master (
    output tx_data_i, tx_valid_i, chan_usb_write_flicker_i, chan_pulpino_read_flicker_i,
           chan_usb_read_flicker_i, chan_rx_word_i, rx_ready_i, abort_i, clr_status_i,
    input  tx_ready_o, tx_level_o, tx_done_o, chan_word_o, chan_load_o, rx_data_o,
           rx_valid_o, busy_o, timeout_o, rx_overflow_o
  );
endinterface

// File: rtl/usb_pulpino_channel_ctrl.sv
// Sequencer for the USB<->Pulpino byte channel: TX word queue + load/drain FSM with
// timeout, RX word assembly with valid/ready and overflow, abort/flush supervision.
module usb_pulpino_channel_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      reset_n_i,
  usb_pulpino_channel_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_tx_ready;
  logic             r_tx_done;
  logic             r_load;
  logic             r_busy;
  logic             r_timeout;
  logic             r_rx_valid;
  logic             r_rx_ovf;
  logic             r_rx_pend;
  logic [31:0]      r_word;
  logic [31:0]      r_rx_data;
  logic [1:0]       r_byte_cnt;
  logic [1:0]       r_rx_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_wr_seen;
  logic             r_rd_seen;
  logic             r_ur_seen;

  logic             w_wr_evt;
  logic             w_rd_evt;
  logic             w_ur_evt;
  logic             w_tmo_hit;
  logic             w_tmo_set;
  logic             w_ovf_set;
  logic             w_push;
  logic             w_pop;
  logic [LVL_W-1:0] w_level_nxt;

  assign w_wr_evt  = bus.chan_usb_write_flicker_i != r_wr_seen;
  assign w_rd_evt  = bus.chan_pulpino_read_flicker_i != r_rd_seen;
  assign w_ur_evt  = bus.chan_usb_read_flicker_i != r_ur_seen;
  // Timeout fires only in a cycle with no handshake event for the current state
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST) &&
                     (((r_state == ST_LOAD) && !w_wr_evt) || ((r_state == ST_DRAIN) && !w_rd_evt));
  assign w_tmo_set = w_tmo_hit && !bus.abort_i;
  assign w_ovf_set = r_rx_pend && r_rx_valid && !bus.rx_ready_i && !bus.abort_i;
  assign w_push    = bus.tx_valid_i && r_tx_ready && !bus.abort_i;
  assign w_pop     = (r_state == ST_LOAD) && (w_wr_evt || w_tmo_hit);
  assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  assign bus.tx_ready_o    = r_tx_ready;
  assign bus.tx_level_o    = r_level;
  assign bus.tx_done_o     = r_tx_done;
  assign bus.chan_word_o   = r_word;
  assign bus.chan_load_o   = r_load;
  assign bus.rx_data_o     = r_rx_data;
  assign bus.rx_valid_o    = r_rx_valid;
  assign bus.busy_o        = r_busy;
  assign bus.timeout_o     = r_timeout;
  assign bus.rx_overflow_o = r_rx_ovf;

  // Queue storage; contents are don't-care until pointed at, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.tx_data_i;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_tx_ready <= 1'b0;
      r_tx_done  <= 1'b0;
      r_load     <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_rx_pend  <= 1'b0;
      r_word     <= '0;
      r_rx_data  <= '0;
      r_byte_cnt <= '0;
      r_rx_cnt   <= '0;
      r_tmo_cnt  <= '0;
      r_wr_seen  <= 1'b0;
      r_rd_seen  <= 1'b0;
      r_ur_seen  <= 1'b0;
    end else begin
      // Every toggle is consumed the cycle it is seen, whether or not the state uses it
      r_wr_seen <= bus.chan_usb_write_flicker_i;
      r_rd_seen <= bus.chan_pulpino_read_flicker_i;
      r_ur_seen <= bus.chan_usb_read_flicker_i;
      r_timeout <= (r_timeout && !bus.clr_status_i) || w_tmo_set;
      r_rx_ovf  <= (r_rx_ovf && !bus.clr_status_i) || w_ovf_set;

      if (bus.abort_i) begin
        r_state    <= ST_IDLE;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_tx_ready <= 1'b1;
        r_tx_done  <= 1'b0;
        r_load     <= 1'b0;
        r_busy     <= 1'b0;
        r_byte_cnt <= '0;
        r_tmo_cnt  <= '0;
        r_rx_cnt   <= '0;
        r_rx_pend  <= 1'b0;
        r_rx_valid <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_level    <= w_level_nxt;
        r_tx_ready <= w_level_nxt != LVL_FULL;

        case (r_state)
          ST_IDLE: begin
            if (r_level != '0) begin
              r_word    <= r_mem[r_rd_ptr];
              r_load    <= 1'b1;
              r_busy    <= 1'b1;
              r_tmo_cnt <= '0;
              r_state   <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (w_wr_evt) begin
              r_load     <= 1'b0;
              r_byte_cnt <= '0;
              r_tmo_cnt  <= '0;
              r_state    <= ST_DRAIN;
            end else if (w_tmo_hit) begin
              r_load  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
          end
          ST_DRAIN: begin
            if (w_rd_evt) begin
              r_tmo_cnt  <= '0;
              r_byte_cnt <= r_byte_cnt + 2'd1;
              if (r_byte_cnt == 2'd3) begin
                r_tx_done <= 1'b1;
                r_state   <= ST_DONE;
              end
            end else if (w_tmo_hit) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
          end
          ST_DONE: begin
            r_tx_done <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase

        // The channel register already holds the full word when the 4th toggle is seen
        if (r_rx_pend) begin
          if (!r_rx_valid || bus.rx_ready_i) begin
            r_rx_data  <= bus.chan_rx_word_i;
            r_rx_valid <= 1'b1;
          end
        end else if (r_rx_valid && bus.rx_ready_i) begin
          r_rx_valid <= 1'b0;
        end
        r_rx_pend <= w_ur_evt && (r_rx_cnt == 2'd3);
        if (w_ur_evt) r_rx_cnt <= r_rx_cnt + 2'd1;
      end
    end
  end
endmodule

// File: doc/usb_pulpino_channel_ctrl.md
Name: usb_pulpino_channel_ctrl

Overview:
Sequencer in front of the USB<->Pulpino byte channel. Queues 32-bit words written from the USB register side, loads them one at a time into the channel, and tracks the toggle handshakes until all 4 bytes are consumed by Pulpino. On the return path it counts received bytes and presents each complete 32-bit Pulpino->USB word with a valid/ready handshake. Also provides timeout, overflow and abort supervision.

Parameters:
FIFO_DEPTH, 4, number of queued TX words (power of 2, >=2)
TIMEOUT_CYCLES, 65535, idle cycles allowed between handshake events before abort (16-bit max)

Ports:
clk  in  1  system clock; all channel signals are synchronous to it
reset_n_i  in  1  asynchronous active-low reset
tx_data_i  in  32  word to send to Pulpino
tx_valid_i  in  1  push request
tx_ready_o  out  1  FIFO not full
tx_level_o  out  $clog2(FIFO_DEPTH+1)  queued word count
tx_done_o  out  1  one-cycle pulse: word fully consumed
chan_word_o  out  32  to channel usb_to_pulpino_reg
chan_load_o  out  1  to channel usb_to_pulpino_read_reg
chan_usb_write_flicker_i  in  1  from channel usb_write_flicker
chan_pulpino_read_flicker_i  in  1  Pulpino byte-read toggle
chan_usb_read_flicker_i  in  1  from channel usb_read_flicker
chan_rx_word_i  in  32  from channel pulpino_to_usb_reg
rx_data_o  out  32  received word
rx_valid_o  out  1  rx_data_o valid
rx_ready_i  in  1  consumer accepts rx word
abort_i  in  1  synchronous flush/abort
clr_status_i  in  1  clears sticky flags
busy_o  out  1  TX FSM not IDLE
timeout_o  out  1  sticky: TX word abandoned
rx_overflow_o  out  1  sticky: RX word dropped

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, FIFO empty, byte counters 0, last-seen flicker copies 0 (matches channel reset).
- Toggle detect: event = input != registered last-seen copy; copy updated in the same cycle the event is consumed.
- FIFO: push when tx_valid_i && tx_ready_o. Push while full ignored, no state change. Simultaneous push and pop: level unchanged. Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE: FIFO non-empty -> chan_word_o <= head, chan_load_o <= 1, go to LOAD (1 cycle, push-to-load latency on an empty FIFO).
- LOAD: hold chan_load_o=1 until usb_write_flicker event; then chan_load_o <= 0, pop FIFO, byte_cnt <= 0, go to DRAIN. chan_word_o is stable throughout LOAD.
- DRAIN: each pulpino_read_flicker event increments byte_cnt; on the 4th event go to DONE. chan_load_o stays 0.
- DONE: tx_done_o=1 for one cycle, then IDLE. chan_load_o is therefore low for >=2 cycles between words.
- Timeout: 16-bit counter cleared on state entry and on every handshake event in LOAD/DRAIN. At TIMEOUT_CYCLES: timeout_o <= 1, chan_load_o <= 0, go to IDLE. In LOAD the word is popped (dropped); in DRAIN the remaining bytes are abandoned.
- RX: each usb_read_flicker event increments 2-bit rx_cnt. On the event that wraps rx_cnt 3->0, the word is complete; capture chan_rx_word_i on the following cycle (the channel register is already updated when the toggle is visible).
  - rx_valid_o=0, or rx_ready_i=1 that cycle: rx_data_o <= word, rx_valid_o <= 1.
  - rx_valid_o=1 and rx_ready_i=0: word dropped, rx_overflow_o <= 1, rx_data_o unchanged.
  - rx_valid_o clears on rx_valid_o && rx_ready_i when no new word lands the same cycle.
- abort_i (priority over all other activity): FSM to IDLE, FIFO flushed, chan_load_o=0, byte_cnt and rx_cnt to 0, rx_valid_o=0, last-seen copies loaded from current inputs; sticky flags kept. Intended to accompany a channel reset.
- clr_status_i clears timeout_o and rx_overflow_o; a set event in the same cycle wins.
- busy_o = (state != IDLE).

Test Plan:
- Push 0xA1B2C3D4, channel write flicker toggles 1 cycle after load, 4 read toggles spaced 3 cycles -> chan_load_o high exactly until the flicker event, tx_done_o pulses once after the 4th toggle, tx_level_o 1->0.
- Push 5 words with FIFO_DEPTH=4 while Pulpino stalls -> 5th push refused (tx_ready_o=0), tx_level_o=4; after draining, words leave in FIFO order.
- No write-flicker response for TIMEOUT_CYCLES=16 -> timeout_o=1 at cycle 16, word dropped, next word loads; clr_status_i clears timeout_o.
- 8 usb_read_flicker toggles carrying bytes 0x11..0x88, rx_ready_i=1 -> rx_data_o=0x44332211 then 0x88776655.
- Same stimulus with rx_ready_i=0 -> first word held, second dropped, rx_overflow_o=1.
- abort_i asserted mid-DRAIN after 2 bytes with 2 words queued -> IDLE next cycle, tx_level_o=0, busy_o=0, no tx_done_o pulse.
